// File: rtl/pll_lock_sequencer_if.sv
// Sequencer-to-system signal bundle; the sequencer is the master.
// Lock and restart inputs plus the reset, status and counter outputs.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked, restart,
    output pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with retries and a fault state; optional loss counter via PLL_SEQ_LOSS_CNT_EN.
// Lock seen 2 cycles after pll_locked (synchronizer), outputs registered; no backpressure.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_FILTER,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          sync1_q, sync2_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          locked_s;

  assign locked_s = sync2_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= bus.pll_locked;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock is tested before the timeout so a coincident lock wins.
        if (locked_s) begin
          if (LOCK_FILTER == 1) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            state_d = S_FILTER;
            cnt_d   = CW'(1);
          end
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + 4'd1;
          state_d = ((retry_q + 4'd1) == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FILTER: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (bus.restart) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change on the transition edge.
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == S_RUN) && !locked_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign bus.loss_cnt = loss_q;
`else
  assign bus.loss_cnt = 8'd0;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt (range 1..255).
REQ-002 Parameter LOCK_FILTER, default 64: consecutive synchronized locked cycles required before release (range 1..65535).
REQ-003 Parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before an attempt fails (range 2..2^20).
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT (range 1..15).
REQ-005 refclk  input  1  free-running sequencer clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 restart  input  1  single-cycle pulse; leaves FAULT.
REQ-009 pll_rst  output  1  reset to the PLL.
REQ-010 sys_rst  output  1  active-high reset for logic on the PLL output clocks.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 retry_cnt  output  4  failed attempts since the last RUN entry or reset.
REQ-014 loss_cnt  output  8  lock losses seen in RUN, saturating at 255.

Function
REQ-015 pll_locked shall pass through a 2-flop synchronizer; locked_s refers to its output, giving 2-cycle latency.
REQ-016 States: RESET_PLL, WAIT_LOCK, FILTER, RUN, FAULT; all outputs registered.
REQ-017 RESET_PLL: pll_rst=1; after exactly RST_CYCLES cycles in this state -> WAIT_LOCK with the counter cleared.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> FILTER; otherwise after LOCK_TIMEOUT cycles retry_cnt increments, then -> FAULT if the new value equals MAX_RETRIES, else -> RESET_PLL.
REQ-019 If locked_s rises in the same cycle as the timeout expires, the lock wins: no increment, -> FILTER.
REQ-020 FILTER: counts consecutive locked_s=1 cycles; locked_s=0 -> WAIT_LOCK with a fresh timeout; count reaching LOCK_FILTER -> RUN.
REQ-021 RUN entry: sys_rst falls and ready rises in the same cycle; retry_cnt clears to 0.
REQ-022 RUN: locked_s=0 -> RESET_PLL; sys_rst=1 and ready=0 on the next cycle; loss_cnt increments and saturates at 255.
REQ-023 FAULT: pll_rst=1, sys_rst=1, fault=1; stays until restart=1 -> RESET_PLL with retry_cnt cleared.
REQ-024 restart is ignored in every state except FAULT.
REQ-025 sys_rst shall be 1 in every state except RUN.
REQ-026 Counters shall be sized to their parameters; no wrap inside any state.

Reset
REQ-027 rst=1 at any cycle, including mid-sequence: state=RESET_PLL, counters=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, synchronizer flops=0.
REQ-028 The RESET_PLL count starts on the first cycle with rst=0.

Configuration
REQ-029 Macro PLL_SEQ_LOSS_CNT_EN defined: loss_cnt behaves per REQ-014/REQ-022.
REQ-030 PLL_SEQ_LOSS_CNT_EN undefined: no counter register; loss_cnt is tied to 0; all other behaviour is identical.

Verification
Use RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
REQ-031 Nominal: release rst; raise pll_locked at cycle 10 -> pll_rst high for cycles 0-3; ready=1 and sys_rst=0 exactly 2+8 cycles after pll_locked rises.
REQ-032 Glitch: locked high 5 cycles, low 1 cycle, then high -> return to WAIT_LOCK; ready only after 8 further consecutive locked cycles.
REQ-033 Retry/fault: pll_locked held 0 -> two 4-cycle pll_rst pulses 32 cycles apart; retry_cnt goes 1, then 2, then fault=1; restart pulse -> fault=0, retry_cnt=0, pll_rst pulse.
REQ-034 Lock loss: in RUN drop pll_locked -> 3 cycles later ready=0, sys_rst=1, pll_rst=1, loss_cnt=1; 256 losses -> loss_cnt=255 (0 with macro undefined).
REQ-035 Race and reset: locked_s rises on the timeout cycle -> FILTER with retry_cnt unchanged; rst asserted during FILTER -> all outputs at reset values on the next cycle.
